// File: rtl/writeback_regfile_if.sv
// MEM/WB-to-writeback bundle plus decode/fetch/forwarding return paths.
// RetireCount is present only when RETIRE_COUNT_EN is defined.
interface writeback_regfile_if #(
    parameter int CNT_W = 32
);
    logic [1:0]  CCR;
    logic        CCRWrite;
    logic [15:0] MemData;
    logic        WriteRF;
    logic [15:0] Imm970s;
    logic [15:0] PCImmInc;
    logic [15:0] ALUOut;
    logic [15:0] PCInc;
    logic [2:0]  WriteAdd;
    logic        WriteR7;
    logic [1:0]  RegWriteSelect;
    logic [2:0]  R7WriteSelect;
    logic [15:0] IR;
    logic [15:0] RFOut2;
    logic [2:0]  RdAdd1;
    logic [2:0]  RdAdd2;
    logic [15:0] RdData1;
    logic [15:0] RdData2;
    logic [15:0] PCOut;
    logic [1:0]  CCROut;
    logic [15:0] WBData;
    logic        WBValid;
`ifdef RETIRE_COUNT_EN
    logic [CNT_W-1:0] RetireCount;
`endif

    modport master (
        output CCR, CCRWrite, MemData, WriteRF, Imm970s, PCImmInc, ALUOut, PCInc,
               WriteAdd, WriteR7, RegWriteSelect, R7WriteSelect, IR, RFOut2,
               RdAdd1, RdAdd2,
        input  RdData1, RdData2, PCOut, CCROut, WBData, WBValid
`ifdef RETIRE_COUNT_EN
        , input RetireCount
`endif
    );

    modport slave (
        input  CCR, CCRWrite, MemData, WriteRF, Imm970s, PCImmInc, ALUOut, PCInc,
               WriteAdd, WriteR7, RegWriteSelect, R7WriteSelect, IR, RFOut2,
               RdAdd1, RdAdd2,
        output RdData1, RdData2, PCOut, CCROut, WBData, WBValid
`ifdef RETIRE_COUNT_EN
        , output RetireCount
`endif
    );
endinterface

// File: rtl/writeback_regfile.sv
// Write-back stage: 8x16 register file with R7 as PC, CCR, and bypassed read ports.
// Optional retire counter enabled by defining RETIRE_COUNT_EN.
module writeback_regfile #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_IR   = 16'hF000,
    parameter int          CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    writeback_regfile_if.slave   bus
);
    logic [15:0] regs_q [8];
    logic [15:0] regs_d [8];
    logic [1:0]  ccr_q, ccr_d;
    logic [15:0] gen_data;
    logic [15:0] r7_data;
    logic        bubble;
    logic        wb_valid;
    logic        r7_we;

    assign bubble   = (bus.IR == NOP_IR);
    assign wb_valid = bus.WriteRF & ~bubble;
    assign r7_we    = bus.WriteR7 & ~bubble;

    always_comb begin
        gen_data = bus.ALUOut;
        case (bus.RegWriteSelect)
            2'b00:   gen_data = bus.ALUOut;
            2'b01:   gen_data = bus.MemData;
            2'b10:   gen_data = bus.Imm970s;
            default: gen_data = bus.PCInc;
        endcase
    end

    always_comb begin
        r7_data = bus.PCInc;
        case (bus.R7WriteSelect)
            3'b001:  r7_data = bus.PCImmInc;
            3'b010:  r7_data = bus.ALUOut;
            3'b011:  r7_data = bus.MemData;
            3'b100:  r7_data = bus.RFOut2;
            default: r7_data = bus.PCInc;
        endcase
    end

    // regs_d is the post-edge state, so reading it gives the bypass for free.
    always_comb begin
        for (int i = 0; i < 8; i++) regs_d[i] = regs_q[i];
        if (wb_valid && bus.WriteAdd != 3'd7) regs_d[bus.WriteAdd] = gen_data;
        if (r7_we)
            regs_d[7] = r7_data;
        else if (wb_valid && bus.WriteAdd == 3'd7)
            regs_d[7] = gen_data;
    end

    assign ccr_d = (bus.CCRWrite && !bubble) ? bus.CCR : ccr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= (i == 7) ? RESET_PC : 16'h0000;
            ccr_q <= 2'b00;
        end else begin
            for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
            ccr_q <= ccr_d;
        end
    end

    assign bus.RdData1 = regs_d[bus.RdAdd1];
    assign bus.RdData2 = regs_d[bus.RdAdd2];
    assign bus.PCOut   = regs_q[7];
    assign bus.CCROut  = ccr_q;
    assign bus.WBData  = gen_data;
    assign bus.WBValid = wb_valid;

`ifdef RETIRE_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d = bubble ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign bus.RetireCount = cnt_q;
`endif
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed-vector bench for writeback_regfile; counter checks compile only
// when RETIRE_COUNT_EN is defined.
module tb_writeback_regfile;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] NOP_IR   = 16'hF000;
    localparam logic [15:0] LIVE_IR  = 16'h1000;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;
    logic [15:0] pc_exp;
    logic [15:0] r7_exp [8];

    writeback_regfile_if #(.CNT_W(32)) wb_if ();

    writeback_regfile #(
        .RESET_PC (RESET_PC),
        .NOP_IR   (NOP_IR),
        .CNT_W    (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (wb_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %-14s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %-14s %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_if.IR       = NOP_IR;
        wb_if.WriteRF  = 1'b0;
        wb_if.WriteR7  = 1'b0;
        wb_if.CCRWrite = 1'b0;
    endtask

    task automatic gen_write(input logic [2:0] add, input logic [1:0] sel, input logic [15:0] exp);
        wb_if.IR             = LIVE_IR;
        wb_if.WriteRF        = 1'b1;
        wb_if.WriteR7        = 1'b0;
        wb_if.WriteAdd       = add;
        wb_if.RegWriteSelect = sel;
        wb_if.RdAdd1         = add;
        wb_if.RdAdd2         = add;
        #1;
        chk("wbvalid", {31'b0, wb_if.WBValid}, 32'd1);
        chk("wbdata", {16'b0, wb_if.WBData}, {16'b0, exp});
        chk("bypass_rd1", {16'b0, wb_if.RdData1}, {16'b0, exp});
        chk("bypass_rd2", {16'b0, wb_if.RdData2}, {16'b0, exp});
        tick();
        idle();
        #1;
        chk("stored", {16'b0, wb_if.RdData1}, {16'b0, exp});
    endtask

`ifdef RETIRE_COUNT_EN
    logic [31:0] cnt_base;
`endif

    initial begin
        n_vec  = 0;
        n_miss = 0;
        reset  = 1'b1;
        wb_if.CCR = 2'b00;       wb_if.CCRWrite = 1'b0;
        wb_if.MemData = 16'h0;   wb_if.WriteRF = 1'b1;
        wb_if.Imm970s = 16'h0;   wb_if.PCImmInc = 16'h0;
        wb_if.ALUOut = 16'h1234; wb_if.PCInc = 16'h0777;
        wb_if.WriteAdd = 3'd7;   wb_if.WriteR7 = 1'b1;
        wb_if.RegWriteSelect = 2'b00; wb_if.R7WriteSelect = 3'b000;
        wb_if.IR = LIVE_IR;      wb_if.RFOut2 = 16'h0;
        wb_if.RdAdd1 = 3'd0;     wb_if.RdAdd2 = 3'd0;

        // Reset held with live writes pending: nothing may stick.
        #2 reset = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 7; i++) begin
            wb_if.RdAdd1 = 3'(i);
            #1;
            chk($sformatf("rst_r%0d", i), {16'b0, wb_if.RdData1}, 32'd0);
        end
        chk("rst_pc", {16'b0, wb_if.PCOut}, {16'b0, RESET_PC});
        chk("rst_ccr", {30'b0, wb_if.CCROut}, 32'd0);

        wb_if.PCInc = 16'h0123;
        reset = 1'b1;
        tick();
        chk("release_pc", {16'b0, wb_if.PCOut}, 32'h0123);
        pc_exp = 16'h0123;
        idle();

        wb_if.ALUOut   = 16'hABCD;
        wb_if.MemData  = 16'h4D4D;
        wb_if.Imm970s  = 16'h9700;
        wb_if.PCInc    = 16'h0124;
        wb_if.PCImmInc = 16'h0200;
        wb_if.RFOut2   = 16'h0500;
        gen_write(3'd3, 2'b00, 16'hABCD);
        gen_write(3'd4, 2'b01, 16'h4D4D);
        gen_write(3'd5, 2'b10, 16'h9700);
        gen_write(3'd6, 2'b11, 16'h0124);

        // Bubble with every enable set.
        wb_if.IR = NOP_IR;
        wb_if.WriteRF = 1'b1; wb_if.WriteAdd = 3'd3; wb_if.RegWriteSelect = 2'b01;
        wb_if.WriteR7 = 1'b1; wb_if.R7WriteSelect = 3'b001;
        wb_if.CCRWrite = 1'b1; wb_if.CCR = 2'b11;
        wb_if.RdAdd1 = 3'd3; wb_if.RdAdd2 = 3'd7;
`ifdef RETIRE_COUNT_EN
        cnt_base = wb_if.RetireCount;
`endif
        #1;
        chk("bub_wbvalid", {31'b0, wb_if.WBValid}, 32'd0);
        chk("bub_nobyp", {16'b0, wb_if.RdData1}, 32'hABCD);
        chk("bub_nobyp7", {16'b0, wb_if.RdData2}, {16'b0, pc_exp});
        tick();
        chk("bub_r3", {16'b0, wb_if.RdData1}, 32'hABCD);
        chk("bub_pc", {16'b0, wb_if.PCOut}, {16'b0, pc_exp});
        chk("bub_ccr", {30'b0, wb_if.CCROut}, 32'd0);
`ifdef RETIRE_COUNT_EN
        chk("bub_cnt", wb_if.RetireCount, cnt_base);
`endif
        idle();

        // R7 source sweep; PCOut must lag, RdData2 must bypass.
        r7_exp[0] = 16'h0124; r7_exp[1] = 16'h0200; r7_exp[2] = 16'hABCD;
        r7_exp[3] = 16'h4D4D; r7_exp[4] = 16'h0500; r7_exp[5] = 16'h0124;
        r7_exp[6] = 16'h0124; r7_exp[7] = 16'h0124;
        for (int s = 0; s < 8; s++) begin
            wb_if.IR = LIVE_IR;
            wb_if.WriteR7 = 1'b1;
            wb_if.R7WriteSelect = 3'(s);
            wb_if.RdAdd2 = 3'd7;
            #1;
            chk($sformatf("r7sel%0d_pre", s), {16'b0, wb_if.PCOut}, {16'b0, pc_exp});
            chk($sformatf("r7sel%0d_byp", s), {16'b0, wb_if.RdData2}, {16'b0, r7_exp[s]});
            tick();
            pc_exp = r7_exp[s];
            chk($sformatf("r7sel%0d_pc", s), {16'b0, wb_if.PCOut}, {16'b0, pc_exp});
        end
        idle();

        // General write to index 7 without WriteR7.
        wb_if.IR = LIVE_IR; wb_if.WriteRF = 1'b1; wb_if.WriteAdd = 3'd7;
        wb_if.RegWriteSelect = 2'b10;
        tick();
        chk("gen_r7", {16'b0, wb_if.PCOut}, 32'h9700);
        idle();

        // Same-cycle conflict: WriteR7 wins.
        wb_if.IR = LIVE_IR; wb_if.WriteRF = 1'b1; wb_if.WriteAdd = 3'd7;
        wb_if.RegWriteSelect = 2'b00; wb_if.ALUOut = 16'h0011;
        wb_if.WriteR7 = 1'b1; wb_if.R7WriteSelect = 3'b100; wb_if.RFOut2 = 16'h0040;
        wb_if.RdAdd1 = 3'd7;
        #1;
        chk("conf_byp", {16'b0, wb_if.RdData1}, 32'h0040);
        tick();
        chk("conf_pc", {16'b0, wb_if.PCOut}, 32'h0040);
        idle();

        // CCR held across a disabled write; counter sees 4 retires.
        tick();
`ifdef RETIRE_COUNT_EN
        cnt_base = wb_if.RetireCount;
`endif
        wb_if.IR = LIVE_IR; wb_if.CCRWrite = 1'b1; wb_if.CCR = 2'b10;
        for (int k = 0; k < 3; k++) tick();
        wb_if.CCRWrite = 1'b0; wb_if.CCR = 2'b01;
        tick();
        chk("ccr_hold", {30'b0, wb_if.CCROut}, 32'd2);
`ifdef RETIRE_COUNT_EN
        chk("cnt_4", wb_if.RetireCount, cnt_base + 32'd4);
        idle();
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1 release dut.cnt_q;
        wb_if.IR = LIVE_IR;
        tick();
        chk("cnt_wrap", wb_if.RetireCount, 32'd0);
`endif
        idle();

        // Asynchronous reset in the middle of a pending write.
        wb_if.IR = LIVE_IR; wb_if.WriteRF = 1'b1; wb_if.WriteAdd = 3'd3;
        wb_if.RegWriteSelect = 2'b00; wb_if.WriteR7 = 1'b1;
        wb_if.R7WriteSelect = 3'b000; wb_if.CCRWrite = 1'b1; wb_if.CCR = 2'b11;
        #3 reset = 1'b0;
        #1;
        chk("async_pc", {16'b0, wb_if.PCOut}, {16'b0, RESET_PC});
        chk("async_ccr", {30'b0, wb_if.CCROut}, 32'd0);
        tick();
        idle();
        reset = 1'b1;
        wb_if.RdAdd1 = 3'd3;
        #1;
        chk("async_r3", {16'b0, wb_if.RdData1}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
Write-back stage that consumes the outputs of the MEM/WB pipeline register. Each cycle it selects the result to retire and writes the 8x16 general register file, R7 (the PC) and the 2-bit condition-code register (CCR). It provides two combinational read ports, with write-to-read bypass, to the decode stage. The current R7 value goes to fetch, and the retiring write goes to the forwarding unit.

Parameters:
RESET_PC, 16'h0000, value loaded into R7 on reset
NOP_IR, 16'hF000, IR encoding of a bubble; such a slot never writes any state
CNT_W, 32, width of retire counter (only with RETIRE_COUNT_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
CCR  in  2  flags produced upstream {carry, zero}
CCRWrite  in  1  update CCR this cycle
MemData  in  16  load data
WriteRF  in  1  enable general register write
Imm970s  in  16  immediate for LHI
PCImmInc  in  16  PC+imm target
ALUOut  in  16  ALU result
PCInc  in  16  PC+1
WriteAdd  in  3  destination register index
WriteR7  in  1  enable R7 write
RegWriteSelect  in  2  general write source select
R7WriteSelect  in  3  R7 write source select
IR  in  16  retiring instruction
RFOut2  in  16  register operand (JLR target)
RdAdd1, RdAdd2  in  3  read addresses
RdData1, RdData2  out  16  read data
PCOut  out  16  current R7
CCROut  out  2  current CCR
WBData  out  16  general write data this cycle
WBValid  out  1  general write occurring this cycle
RetireCount  out  CNT_W  retired instructions (only with RETIRE_COUNT_EN)

Behaviour:
- Reset (reset=0, asynchronous):
  - R0..R6 = 0, R7 = RESET_PC, CCROut = 00.
  - Outputs follow combinationally from the cleared state.
  - Reset asserted mid-write discards that write.
- bubble = (IR == NOP_IR). A bubble suppresses all three writes: general, R7 and CCR.
- General write data by RegWriteSelect:
  - 00 ALUOut
  - 01 MemData
  - 10 Imm970s
  - 11 PCInc
- R7 write data by R7WriteSelect:
  - 000 PCInc
  - 001 PCImmInc
  - 010 ALUOut
  - 011 MemData
  - 100 RFOut2
  - 101..111 treated as PCInc
- WBData = general write data, always driven.
- WBValid = WriteRF & ~bubble, combinational.
- All writes take effect at the rising clk edge; latency is 1 cycle to architectural state.
- General write:
  - If WBValid and WriteAdd != 7, R[WriteAdd] <= WBData.
  - If WriteAdd == 7 and WriteR7 == 0, R7 <= WBData.
- R7 write: if WriteR7 & ~bubble, R7 <= R7 data. WriteR7 has priority over a general write to index 7 in the same cycle.
- CCR: if CCRWrite & ~bubble, CCROut <= CCR. This is independent of the register writes.
- Reads are combinational: RdDataN = R[RdAddN], except for bypass.
- Bypass: if a write to RdAddN commits at the next edge, RdDataN returns the value being written, not the stale value.
  - Applies to index 7 via the R7 priority rule.
  - Both read ports can bypass simultaneously, including when they use the same address.
- PCOut = R7 register value only; it is not bypassed.
- No stall input: every cycle retires whatever the MEM/WB register presents.

Optional Feature:
RETIRE_COUNT_EN:
- When defined, RetireCount exists. It resets to 0, increments by 1 on every edge where ~bubble, and wraps from all-ones to 0.
- When not defined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=0 with WriteRF=1, IR=16'h1000 -> R0..R6=0, PCOut=RESET_PC, CCROut=00; release -> writes resume next edge.
- ALU write: WriteRF=1, WriteAdd=3, RegWriteSelect=00, ALUOut=16'hABCD, RdAdd1=3 -> RdData1=16'hABCD in the same cycle (bypass) and after the edge (stored).
- Bubble: IR=NOP_IR, WriteRF=1, WriteR7=1, CCRWrite=1 -> no register, R7 or CCR change; WBValid=0; RetireCount unchanged.
- R7 conflict:
  - Stimulus: WriteRF=1, WriteAdd=7, ALUOut=16'h0011, WriteR7=1, R7WriteSelect=100, RFOut2=16'h0040.
  - Response: PCOut=16'h0040 after the edge.
- CCR and counter:
  - Stimulus: CCRWrite=1, CCR=10 for 3 non-NOP cycles, then CCRWrite=0, CCR=01.
  - Response: CCROut stays 10; RetireCount=4 after 4 non-NOP edges.
  - Wrap check: force the counter to all-ones, then one retire -> 0.
